vro_host: RTL and testbench

- Initiator and checker end of the serial vector-reverse stream.
- Takes one parallel vector and sends it as a framed 3-bit-per-beat serial burst on tx_valid/tx_data, which drives the reverse-ordering engine's input.
- Captures the engine's returned burst on rx_valid/rx_data and checks it is exactly the sent vector in reverse order.
- Reports pass, fail or timeout, together with the captured result.

---
 rtl/vro_host.sv | 253 +++++++++++++++++++++++++
 tb/tb_vro_host.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vro_host.sv
// ---------------------------------------------------------------------------
// vro_host
//
// Initiator and checker end of the serial vector-reverse stream. A parallel
// vector is latched on start, sent out as a framed burst of LEN beats (one
// DW-bit element per beat, element 0 first), and the burst returned by the
// reverse-ordering engine is captured and checked against the sent vector in
// reverse order. The outcome is reported with a one-cycle done strobe.
//
// Optional feature (compile-time macro VRO_HOST_ERRCNT_EN):
//   When defined, adds the err_beats output carrying the number of returned
//   beats that did not match in the last transaction. Beats that never
//   arrived count as mismatches. When undefined, the port and its counter
//   are absent and everything else behaves the same.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   start        in   request to send vec_in (only looked at in IDLE)
//   vec_in       in   DW*LEN vector, element k at vec_in[DW*k +: DW]
//   busy         out  high from the cycle after start is accepted until the
//                     block returns to IDLE
//   tx_valid     out  outgoing burst valid
//   tx_data      out  outgoing element, 0 while tx_valid is low
//   rx_valid     in   returned burst valid
//   rx_data      in   returned element
//   done         out  one-cycle result strobe
//   pass         out  result: burst matched, no timeout (held until next done)
//   timeout_err  out  result: no return burst arrived (held until next done)
//   err_beats    out  mismatching beat count (VRO_HOST_ERRCNT_EN only)
//   rx_result    out  captured return vector, beat j at rx_result[DW*j +: DW]
// ---------------------------------------------------------------------------
module vro_host #(
  parameter int DW      = 3,
  parameter int LEN     = 6,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DW*LEN-1:0]        vec_in,
  output logic                     busy,
  output logic                     tx_valid,
  output logic [DW-1:0]            tx_data,
  input  logic                     rx_valid,
  input  logic [DW-1:0]            rx_data,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout_err,
`ifdef VRO_HOST_ERRCNT_EN
  output logic [$clog2(LEN+1)-1:0] err_beats,
`endif
  output logic [DW*LEN-1:0]        rx_result
);

  localparam int CW = $clog2(LEN);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    REPORT
  } state_t;

  state_t              r_state;
  logic [DW*LEN-1:0]   r_vec;
  logic [CW-1:0]       r_beat;
  logic [WW-1:0]       r_wait;
  logic                r_fail;
  logic                r_busy;
  logic                r_txValid;
  logic [DW-1:0]       r_txData;
  logic                r_done;
  logic                r_pass;
  logic                r_timeoutErr;
  logic [DW*LEN-1:0]   r_rxResult;

  logic [DW-1:0]       w_txElem;
  logic [DW-1:0]       w_expElem;
  logic [DW*LEN-1:0]   w_rxNext;
  logic                w_beatBad;
  logic                w_waitExpired;

  // The one beat counter selects the outgoing element while sending and the
  // capture slot while receiving; the expected return element mirrors it
  // from the far end of the latched vector.
  always_comb begin
    w_txElem  = '0;
    w_expElem = '0;
    w_rxNext  = r_rxResult;
    for (int k = 0; k < LEN; k++) begin
      if (r_beat == CW'(k)) begin
        w_txElem              = r_vec[DW*k +: DW];
        w_expElem             = r_vec[DW*(LEN-1-k) +: DW];
        w_rxNext[DW*k +: DW]  = rx_data;
      end
    end
  end

  assign w_beatBad     = (rx_data != w_expElem);
  assign w_waitExpired = (r_wait == WW'(TIMEOUT));

  // Main sequencer. Every output is a register written here so nothing
  // combinational leaks onto the ports. done is raised on the edge that
  // enters REPORT, so it is visible for exactly the one cycle spent there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_vec        <= '0;
      r_beat       <= '0;
      r_wait       <= '0;
      r_fail       <= 1'b0;
      r_busy       <= 1'b0;
      r_txValid    <= 1'b0;
      r_txData     <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_rxResult   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_txValid <= 1'b0;
      r_txData  <= '0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vec   <= vec_in;
            r_beat  <= '0;
            r_wait  <= '0;
            r_fail  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SEND;
          end
        end
        SEND: begin
          r_txValid <= 1'b1;
          r_txData  <= w_txElem;
          if (r_beat == LAST_BEAT) begin
            r_beat  <= '0;
            r_wait  <= '0;
            r_state <= WAIT;
          end else begin
            r_beat <= r_beat + CW'(1);
          end
        end
        WAIT: begin
          if (rx_valid) begin
            r_rxResult <= w_rxNext;
            r_fail     <= r_fail | w_beatBad;
            r_beat     <= r_beat + CW'(1);
            r_state    <= RECV;
          end else if (w_waitExpired) begin
            r_done       <= 1'b1;
            r_pass       <= 1'b0;
            r_timeoutErr <= 1'b1;
            r_state      <= REPORT;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        RECV: begin
          if (rx_valid) begin
            r_rxResult <= w_rxNext;
            r_fail     <= r_fail | w_beatBad;
            if (r_beat == LAST_BEAT) begin
              r_done       <= 1'b1;
              r_pass       <= ~(r_fail | w_beatBad);
              r_timeoutErr <= 1'b0;
              r_state      <= REPORT;
            end else begin
              r_beat <= r_beat + CW'(1);
            end
          end else begin
            // Burst ended short: treat as a failed transfer.
            r_fail       <= 1'b1;
            r_done       <= 1'b1;
            r_pass       <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_state      <= REPORT;
          end
        end
        REPORT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef VRO_HOST_ERRCNT_EN
  localparam int EW = $clog2(LEN + 1);

  logic [EW-1:0] r_errCnt;
  logic [EW-1:0] r_errBeats;
  logic [EW-1:0] w_errNext;
  logic [EW-1:0] w_missing;

  assign w_errNext = r_errCnt + EW'(w_beatBad);
  // On a short burst r_beat holds how many beats were captured.
  assign w_missing = EW'(LEN) - EW'(r_beat);

  // Running mismatch count; the published value is only updated on the
  // edge that raises done, so it lines up with pass/timeout_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_errCnt   <= '0;
      r_errBeats <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_errCnt   <= '0;
            r_errBeats <= '0;
          end
        end
        WAIT: begin
          if (rx_valid) begin
            r_errCnt <= w_errNext;
          end else if (w_waitExpired) begin
            r_errBeats <= EW'(LEN);
          end
        end
        RECV: begin
          if (rx_valid) begin
            r_errCnt <= w_errNext;
            if (r_beat == LAST_BEAT) begin
              r_errBeats <= w_errNext;
            end
          end else begin
            r_errBeats <= r_errCnt + w_missing;
          end
        end
        default: ;
      endcase
    end
  end

  assign err_beats = r_errBeats;
`endif

  assign busy        = r_busy;
  assign tx_valid    = r_txValid;
  assign tx_data     = r_txData;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout_err = r_timeoutErr;
  assign rx_result   = r_rxResult;

endmodule

// File: tb/tb_vro_host.sv
// ---------------------------------------------------------------------------
// tb_vro_host
//
// Directed bench for vro_host. A transaction-level model predicts every
// output cycle by cycle from the start edge, the burst timing rules and the
// list of returned beats; a single negedge process compares the DUT to it.
// Directed scenarios add literal expectations (beat values, captured
// vector, done latency) that pin the model itself.
// ---------------------------------------------------------------------------
module tb_vro_host;

  localparam int DW      = 3;
  localparam int LEN     = 6;
  localparam int TIMEOUT = 15;
  localparam int EW      = $clog2(LEN + 1);

  localparam logic [DW*LEN-1:0] VEC_A   = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [DW*LEN-1:0] RET_A   = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  localparam logic [DW*LEN-1:0] RET_BAD = {3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd6};
  localparam logic [DW*LEN-1:0] VEC_B   = {3'd4, 3'd1, 3'd5, 3'd0, 3'd7, 3'd3};
  localparam logic [DW*LEN-1:0] RET_B   = {3'd3, 3'd7, 3'd0, 3'd5, 3'd1, 3'd4};
  localparam logic [DW*LEN-1:0] VEC_C   = {3'd2, 3'd2, 3'd7, 3'd7, 3'd0, 3'd1};

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DW*LEN-1:0] vec_in;
  logic              busy;
  logic              tx_valid;
  logic [DW-1:0]     tx_data;
  logic              rx_valid;
  logic [DW-1:0]     rx_data;
  logic              done;
  logic              pass;
  logic              timeout_err;
  logic [DW*LEN-1:0] rx_result;
`ifdef VRO_HOST_ERRCNT_EN
  logic [EW-1:0]     err_beats;
`endif

  vro_host #(.DW(DW), .LEN(LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vec_in      (vec_in),
    .busy        (busy),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .done        (done),
    .pass        (pass),
    .timeout_err (timeout_err),
`ifdef VRO_HOST_ERRCNT_EN
    .err_beats   (err_beats),
`endif
    .rx_result   (rx_result)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transaction is anchored at its start edge T.
  // Beats go out on edges T+1..T+LEN, the return burst is collected as a
  // list, and the outcome is judged from that list once it completes, breaks
  // off, or the no-response deadline (TIMEOUT+1 edges after the last beat
  // edge) passes.
  int                cyc = 0;
  bit                mActive = 0;
  bit                mDoneSet = 0;
  bit                mCap = 0;
  int                mT = 0;
  int                mDoneEdge = 0;
  logic [DW*LEN-1:0] mVec = '0;
  logic [DW-1:0]     mRx[$];
  logic              eBusy = 0, eTxValid = 0, eDone = 0, ePass = 0, eTo = 0;
  logic [DW-1:0]     eTxData = '0;
  logic [DW*LEN-1:0] eRes = '0;
  int                eErr = 0;

  task automatic finishTxn(input bit isTo);
    int nBad;
    nBad = LEN - mRx.size();
    for (int j = 0; j < mRx.size(); j++)
      if (mRx[j] != mVec[DW*(LEN-1-j) +: DW]) nBad++;
    mDoneSet  = 1;
    mDoneEdge = cyc;
    eDone     = 1;
    eTo       = isTo;
    ePass     = !isTo && (nBad == 0);
    eErr      = nBad;
  endtask

  always @(posedge clk) begin
    int k;
    cyc++;
    eDone    = 0;
    eTxValid = 0;
    eTxData  = '0;
    k        = cyc - mT;
    if (rst) begin
      mActive = 0;
      eBusy   = 0;
      ePass   = 0;
      eTo     = 0;
      eRes    = '0;
      eErr    = 0;
    end else if (mActive && mDoneSet && cyc == mDoneEdge + 1) begin
      mActive = 0;
      eBusy   = 0;
    end else if (!mActive) begin
      if (start) begin
        mActive  = 1;
        mT       = cyc;
        mVec     = vec_in;
        mRx.delete();
        mCap     = 0;
        mDoneSet = 0;
        eBusy    = 1;
        eErr     = 0;
      end
    end else if (!mDoneSet) begin
      if (k <= LEN) begin
        eTxValid = 1;
        eTxData  = mVec[DW*(k-1) +: DW];
      end else if (rx_valid) begin
        mCap = 1;
        eRes[DW*mRx.size() +: DW] = rx_data;
        mRx.push_back(rx_data);
        if (mRx.size() == LEN) finishTxn(0);
      end else if (mCap) begin
        finishTxn(0);
      end else if (cyc == mT + LEN + TIMEOUT + 1) begin
        finishTxn(1);
      end
    end
  end

  // Compare process: control/data outputs every cycle, result qualifiers
  // whenever a done is expected or seen.
  always @(negedge clk) begin
    checkOutput("busy", busy, eBusy);
    checkOutput("tx_valid", tx_valid, eTxValid);
    checkOutput("tx_data", tx_data, eTxData);
    checkOutput("done", done, eDone);
    if (eDone || done) begin
      checkOutput("pass", pass, ePass);
      checkOutput("timeout_err", timeout_err, eTo);
      checkOutput("rx_result", rx_result, eRes);
`ifdef VRO_HOST_ERRCNT_EN
      checkOutput("err_beats", err_beats, eErr);
`endif
    end
  end

  // Observation log for the directed literal checks.
  int                ncyc = 0;
  int                doneCount = 0;
  int                doneNeg = 0;
  int                lastTxNeg = 0;
  int                dropNeg = 0;
  logic [DW-1:0]     txLog[$];
  logic              lastPass = 0, lastTo = 0;
  logic [DW*LEN-1:0] lastRes = '0;
  logic [31:0]       lastErr = 0;

  always @(negedge clk) begin
    ncyc++;
    if (tx_valid) begin
      txLog.push_back(tx_data);
      lastTxNeg = ncyc;
    end
    if (done) begin
      doneCount++;
      doneNeg  = ncyc;
      lastPass = pass;
      lastTo   = timeout_err;
      lastRes  = rx_result;
`ifdef VRO_HOST_ERRCNT_EN
      lastErr  = 32'(err_beats);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One full transaction: send vec, return nRet beats of ret starting two
  // cycles after tx_valid falls, then wait (bounded) for done. With disturb
  // set, a second start with a different vector is pulsed mid-burst.
  task automatic applyStimulus(input logic [DW*LEN-1:0] vec,
                               input logic [DW*LEN-1:0] ret,
                               input int nRet, input bit disturb);
    int  d0;
    bit  seen;
    bit  ended;
    d0    = doneCount;
    seen  = 0;
    ended = 0;
    txLog.delete();
    start  = 1'b1;
    vec_in = vec;
    for (int i = 0; i < 40; i++) begin
      tick();
      start = (disturb && i == 2);
      if (disturb && i == 2) vec_in = VEC_C;
      if (tx_valid) seen = 1;
      else if (seen) begin
        ended = 1;
        break;
      end
    end
    start = 1'b0;
    checkOutput("burst ended", 32'(ended), 1);
    tick();
    tick();
    for (int j = 0; j < nRet; j++) begin
      rx_valid = 1'b1;
      rx_data  = ret[DW*j +: DW];
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = '0;
    dropNeg  = ncyc;
    for (int i = 0; i < 40; i++) begin
      if (doneCount != d0) break;
      tick();
    end
    checkOutput("done count", 32'(doneCount - d0), 1);
    repeat (3) tick();
  endtask

  task automatic checkBeats(input logic [DW*LEN-1:0] vec);
    checkOutput("tx beat count", 32'(txLog.size()), LEN);
    for (int j = 0; j < LEN && j < txLog.size(); j++)
      checkOutput("tx beat", 32'(txLog[j]), 32'(vec[DW*j +: DW]));
  endtask

  initial begin
    int d0;
    rst      = 1'b1;
    start    = 1'b0;
    vec_in   = '0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) tick();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset tx_valid", tx_valid, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset pass", pass, 0);
    checkOutput("reset rx_result", rx_result, 0);
    rst = 1'b0;
    tick();

    $display("[TB] normal pass");
    applyStimulus(VEC_A, RET_A, LEN, 0);
    checkBeats(VEC_A);
    checkOutput("normal first beat", 32'(txLog.size() > 0 ? txLog[0] : 3'd0), 1);
    checkOutput("normal pass", lastPass, 1);
    checkOutput("normal timeout", lastTo, 0);
    checkOutput("normal rx_result", lastRes, RET_A);

    $display("[TB] mismatch");
    applyStimulus(VEC_A, RET_BAD, LEN, 0);
    checkOutput("mismatch pass", lastPass, 0);
    checkOutput("mismatch timeout", lastTo, 0);
    checkOutput("mismatch rx_result", lastRes, RET_BAD);
`ifdef VRO_HOST_ERRCNT_EN
    checkOutput("mismatch err_beats", lastErr, 1);
`endif

    $display("[TB] timeout");
    applyStimulus(VEC_A, '0, 0, 0);
    checkOutput("timeout flag", lastTo, 1);
    checkOutput("timeout pass", lastPass, 0);
    checkOutput("timeout latency", 32'(doneNeg - lastTxNeg), TIMEOUT + 1);
`ifdef VRO_HOST_ERRCNT_EN
    checkOutput("timeout err_beats", lastErr, LEN);
`endif

    $display("[TB] framing error");
    applyStimulus(VEC_A, RET_A, 3, 0);
    checkOutput("framing pass", lastPass, 0);
    checkOutput("framing timeout", lastTo, 0);
    checkOutput("framing latency", 32'(doneNeg - dropNeg), 1);
`ifdef VRO_HOST_ERRCNT_EN
    checkOutput("framing err_beats", lastErr, 3);
`endif

    $display("[TB] start while busy");
    applyStimulus(VEC_B, RET_B, LEN, 1);
    checkBeats(VEC_B);
    checkOutput("busy-start pass", lastPass, 1);
    repeat (30) tick();
    checkOutput("no second burst", 32'(txLog.size()), LEN);
    checkOutput("idle after", busy, 0);

    $display("[TB] reset mid-send");
    txLog.delete();
    d0     = doneCount;
    start  = 1'b1;
    vec_in = VEC_A;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (txLog.size() >= 3) break;
      tick();
    end
    checkOutput("third beat reached", 32'(txLog.size()), 3);
    rst = 1'b1;
    tick();
    checkOutput("abort tx_valid", tx_valid, 0);
    checkOutput("abort busy", busy, 0);
    rst = 1'b0;
    repeat (30) tick();
    checkOutput("abort no done", 32'(doneCount - d0), 0);
    checkOutput("abort no beats", 32'(txLog.size()), 3);
    applyStimulus(VEC_A, RET_A, LEN, 0);
    checkBeats(VEC_A);
    checkOutput("after abort pass", lastPass, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
